fetch_sequencer: RTL and testbench

Sequencing controller in front of the combinational Y86-64 fetch stage. It owns the PC register and fetches aligned 64-bit words from instruction memory over a one-outstanding request/response handshake, packing them into a 24-byte byte queue. It presents an 80-bit instruction window starting at PC to the fetch stage, and advances PC by the decoded length on each downstream accept. It handles redirects (jump, ret, mispredict) and halts on HLT, invalid icode, or memory error, reporting a Y86 status code.

---
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Y86-64 fetch sequencer: owns PC, streams aligned instruction words
// into a 24-byte queue and presents an 80-bit window to the fetch stage.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [63:0] imem_rdata_i,
    input  logic        imem_err_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [63:0] pc_o,
    output logic [79:0] instruction_o,
    output logic [2:0]  stat_o
);

    typedef enum logic [1:0] {S_RUN, S_HLT, S_ADR, S_INS} state_e;

    state_e       state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  fa_q, fa_d;
    logic [2:0]   skip_q, skip_d;
    logic [4:0]   count_q, count_d;
    logic [191:0] queue_q, queue_d;
    logic         out_q, out_d;
    logic         disc_q, disc_d;
    logic         err_q, err_d;

    logic         run;
    logic [3:0]   icode;
    logic [3:0]   head_len;
    logic         xfer;
    logic [3:0]   consumed;
    logic         resp;
    logic         append;
    logic [3:0]   app_n;
    logic [4:0]   base;
    logic [63:0]  word_sh;
    logic [191:0] shifted;
    logic [191:0] app_vec;

    function automatic logic [3:0] inst_len(input logic [3:0] ic);
        logic [3:0] l;
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: l = 4'd2;
            4'h7, 4'h8:             l = 4'd9;
            4'h3, 4'h4, 4'h5:       l = 4'd10;
            default:                l = 4'd1;
        endcase
        return l;
    endfunction

    // Bytes past count are kept zero, so an empty queue decodes as icode 0.
    assign icode    = queue_q[7:4];
    assign head_len = inst_len(icode);
    assign run      = (state_q == S_RUN);

    assign inst_valid_o  = run && (count_q >= 5'(head_len)) && !redirect_i;
    assign imem_req_o    = run && !out_q && (count_q <= 5'd16)
                           && !redirect_i && !err_q;
    assign imem_addr_o   = fa_q;
    assign pc_o          = pc_q;
    assign instruction_o = queue_q[79:0];

    assign xfer     = inst_valid_o && inst_ready_i;
    assign consumed = xfer ? head_len : 4'd0;
    assign resp     = imem_rvalid_i && out_q;
    assign append   = resp && !disc_q && !imem_err_i;
    assign app_n    = append ? (4'd8 - {1'b0, skip_q}) : 4'd0;
    assign base     = count_q - 5'(consumed);
    assign word_sh  = imem_rdata_i >> {skip_q, 3'b000};
    assign shifted  = queue_q >> {consumed, 3'b000};
    assign app_vec  = {128'b0, word_sh} << {base, 3'b000};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fa_d    = fa_q;
        skip_d  = skip_q;
        count_d = count_q;
        queue_d = queue_q;
        out_d   = out_q;
        disc_d  = disc_q;
        err_d   = err_q;
        if (redirect_i) begin
            state_d = S_RUN;
            pc_d    = redirect_pc_i;
            fa_d    = {redirect_pc_i[63:3], 3'b000};
            skip_d  = redirect_pc_i[2:0];
            count_d = 5'd0;
            queue_d = '0;
            err_d   = 1'b0;
            // An in-flight response still has to drain before refetching.
            disc_d  = out_q && !imem_rvalid_i;
            out_d   = out_q && !imem_rvalid_i;
        end else begin
            if (resp) begin
                out_d = 1'b0;
                if (disc_q)
                    disc_d = 1'b0;
                else if (imem_err_i)
                    err_d = 1'b1;
                else
                    skip_d = 3'd0;
            end
            queue_d = shifted | (append ? app_vec : '0);
            count_d = base + 5'(app_n);
            if (xfer)
                pc_d = pc_q + 64'(head_len);
            if (imem_req_o) begin
                out_d = 1'b1;
                fa_d  = fa_q + 64'd8;
            end
            unique case (state_q)
                S_RUN: begin
                    if (xfer && icode == 4'h0)
                        state_d = S_HLT;
                    else if (xfer && icode >= 4'hC)
                        state_d = S_INS;
                    else if (err_q && count_q < 5'(head_len))
                        state_d = S_ADR;
                end
                S_HLT, S_ADR, S_INS: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        stat_o = 3'd1;
        unique case (state_q)
            S_RUN: stat_o = 3'd1;
            S_HLT: stat_o = 3'd2;
            S_ADR: stat_o = 3'd3;
            S_INS: stat_o = 3'd4;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            fa_q    <= {RESET_PC[63:3], 3'b000};
            skip_q  <= RESET_PC[2:0];
            count_q <= 5'd0;
            queue_q <= '0;
            out_q   <= 1'b0;
            disc_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fa_q    <= fa_d;
            skip_q  <= skip_d;
            count_q <= count_d;
            queue_q <= queue_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte-queue reference model, latency-configurable
// instruction memory, directed scenarios and a randomized redirect/stall run.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [63:0] imem_rdata_i;
    logic        imem_err_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [63:0] pc_o;
    logic [79:0] instruction_o;
    logic [2:0]  stat_o;

    fetch_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .imem_err_i(imem_err_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .pc_o(pc_o), .instruction_o(instruction_o), .stat_o(stat_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    bit          err_en;
    logic [7:0]  err_lo;
    int          lat;
    bit          pend;
    int          pend_due;
    logic [63:0] pend_addr;

    logic [63:0] m_pc, m_fa;
    logic [2:0]  m_skip;
    bit          m_out, m_disc, m_err;
    int          m_stat;
    logic [7:0]  m_q [$];

    bit          s_redir, s_ready;
    logic [63:0] s_rpc;
    int          checks, errors, cyc;

    logic [63:0] log_pc [$];
    logic [3:0]  log_ic [$];
    bit          arm_req, arm_val;
    int          arm_cyc, req_cyc, val_cyc;
    logic [63:0] req_addr, val_pc;
    logic [7:0]  val_byte;

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 1;
        endcase
    endfunction

    function automatic logic [63:0] memword(input logic [63:0] a);
        logic [63:0] w;
        logic [7:0]  b;
        for (int k = 0; k < 8; k++) begin
            b = a[7:0] + 8'(k);
            w[8*k +: 8] = mem[b];
        end
        return w;
    endfunction

    task automatic check(input string nm, input logic [79:0] act,
                         input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc = 64'h0; m_fa = 64'h0; m_skip = 3'd0;
        m_out = 0; m_disc = 0; m_err = 0; m_stat = 1;
        m_q.delete();
        pend = 0;
    endtask

    task automatic cycle();
        logic [7:0]  hb;
        logic [79:0] mi;
        logic [63:0] w;
        int          len, n;
        bit          mv, mr, rv, xf, adr;
        @(negedge clk);
        redirect_i    = s_redir;
        redirect_pc_i = s_rpc;
        inst_ready_i  = s_ready;
        rv = pend && (pend_due == cyc);
        w  = memword(pend_addr);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? w : {$urandom, $urandom};
        imem_err_i    = rv ? (err_en && pend_addr[7:0] == err_lo)
                           : 1'($urandom_range(0, 1));
        #1;
        n  = m_q.size();
        hb = (n > 0) ? m_q[0] : 8'h00;
        len = ilen(hb[7:4]);
        mv = (m_stat == 1) && (n >= len) && !s_redir;
        mr = (m_stat == 1) && !m_out && (n <= 16) && !s_redir && !m_err;
        mi = '0;
        for (int k = 0; k < 10; k++)
            if (k < n) mi[8*k +: 8] = m_q[k];
        check("req", 80'(imem_req_o), 80'(mr));
        check("addr", 80'(imem_addr_o), 80'(m_fa));
        check("valid", 80'(inst_valid_o), 80'(mv));
        check("pc", 80'(pc_o), 80'(m_pc));
        check("instr", instruction_o, mi);
        check("stat", 80'(stat_o), 80'(m_stat));
        if (inst_valid_o && inst_ready_i) begin
            log_pc.push_back(pc_o);
            log_ic.push_back(instruction_o[7:4]);
        end
        if (arm_req && imem_req_o) begin
            arm_req = 0; req_cyc = cyc - arm_cyc; req_addr = imem_addr_o;
        end
        if (arm_val && inst_valid_o) begin
            arm_val = 0; val_cyc = cyc - arm_cyc;
            val_pc = pc_o; val_byte = instruction_o[7:0];
        end
        @(posedge clk);
        if (rv) pend = 0;
        if (mr) begin
            pend = 1; pend_due = cyc + lat; pend_addr = m_fa;
        end
        if (s_redir) begin
            m_disc = m_out && !rv;
            m_out  = m_out && !rv;
            m_pc   = s_rpc;
            m_q.delete();
            m_fa   = {s_rpc[63:3], 3'b000};
            m_skip = s_rpc[2:0];
            m_err  = 0;
            m_stat = 1;
        end else begin
            adr = (m_stat == 1) && m_err && (n < len);
            xf  = mv && s_ready;
            if (xf) begin
                repeat (len) void'(m_q.pop_front());
                m_pc = m_pc + 64'(len);
                if (hb[7:4] == 4'h0) m_stat = 2;
                else if (hb[7:4] >= 4'hC) m_stat = 4;
            end else if (adr) begin
                m_stat = 3;
            end
            if (rv) begin
                m_out = 0;
                if (m_disc) m_disc = 0;
                else if (imem_err_i) m_err = 1;
                else begin
                    for (int k = int'(m_skip); k < 8; k++)
                        m_q.push_back(w[8*k +: 8]);
                    m_skip = 3'd0;
                end
            end
            if (mr) begin
                m_out = 1;
                m_fa  = m_fa + 64'd8;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect_to(input logic [63:0] a);
        s_redir = 1; s_rpc = a;
        cycle();
        s_redir = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        s_redir = 0; redirect_i = 0; redirect_pc_i = '0;
        imem_rvalid_i = 0; imem_err_i = 0; imem_rdata_i = '0;
        inst_ready_i = s_ready;
        #1;
        check("rst_valid", 80'(inst_valid_o), 80'(0));
        check("rst_stat", 80'(stat_o), 80'(1));
        check("rst_pc", 80'(pc_o), 80'(0));
        check("rst_instr", instruction_o, 80'(0));
        check("rst_addr", 80'(imem_addr_o), 80'(0));
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        int start;
        logic [7:0] b;
        checks = 0; errors = 0; cyc = 0;
        lat = 1; err_en = 0; err_lo = 8'h00;
        s_ready = 1; s_redir = 0; s_rpc = '0;
        arm_req = 0; arm_val = 0; arm_cyc = 0;
        req_cyc = -1; val_cyc = -1; req_addr = '0; val_pc = '0; val_byte = '0;
        rst = 1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        begin
            logic [127:0] prog;
            prog = 128'h0000_8A60_8A20_0000_0000_0000_0000_08F8_30 >> 0;
            prog = {64'h00_00_8A_60_8A_20_00_00, 64'h00_00_00_00_00_08_F8_30};
            for (int i = 0; i < 16; i++) mem[i] = prog[8*i +: 8];
        end

        // program from reset: irmovq, rrmovq, addq, halt
        do_reset();
        arm_val = 1; arm_cyc = 0;
        run(14);
        check("t1_ntx", 80'(log_pc.size()), 80'(4));
        if (log_pc.size() == 4) begin
            check("t1_pc0", 80'(log_pc[0]), 80'(0));
            check("t1_pc1", 80'(log_pc[1]), 80'(10));
            check("t1_pc2", 80'(log_pc[2]), 80'(12));
            check("t1_pc3", 80'(log_pc[3]), 80'(14));
            check("t1_ic3", 80'(log_ic[3]), 80'(0));
        end
        check("t1_first_valid_cyc", 80'(val_cyc), 80'(4));
        check("t1_stat", 80'(stat_o), 80'(2));
        check("t1_noreq", 80'(imem_req_o), 80'(0));

        // unaligned redirect
        arm_req = 1; arm_val = 1; arm_cyc = cyc;
        redirect_to(64'h0D);
        run(10);
        check("t2_req_addr", 80'(req_addr), 80'(64'h08));
        check("t2_pc", 80'(val_pc), 80'(64'h0D));
        check("t2_byte", 80'(val_byte), 80'(8'h8A));

        // redirect with a response in flight, latency 3
        for (int i = 8'h80; i < 8'h90; i++) mem[i] = 8'h90;
        for (int i = 8'hA0; i < 8'hB0; i++) mem[i] = 8'h10;
        mem[8'hA3] = 8'h20; mem[8'hA4] = 8'h11;
        s_ready = 1; lat = 3;
        do_reset();
        redirect_to(64'h80);
        run(2);
        arm_req = 1; arm_val = 1; arm_cyc = cyc;
        redirect_to(64'hA3);
        run(14);
        check("t3_req_gap", 80'(req_cyc), 80'(2));
        check("t3_req_addr", 80'(req_addr), 80'(64'hA0));
        check("t3_pc", 80'(val_pc), 80'(64'hA3));
        check("t3_byte", 80'(val_byte), 80'(8'h20));

        // stalled downstream fills the queue
        for (int i = 0; i < 256; i++) mem[i] = 8'h10;
        lat = 1; s_ready = 0;
        redirect_to(64'h20);
        run(20);
        check("t4_pc", 80'(pc_o), 80'(64'h20));
        check("t4_noreq", 80'(imem_req_o), 80'(0));
        check("t4_instr", instruction_o, {10{8'h10}});
        s_ready = 1;
        run(5);

        // memory error on the second word
        for (int i = 8'h40; i < 8'h48; i += 2) begin
            mem[i] = 8'h20; mem[i+1] = 8'h12;
        end
        err_en = 1; err_lo = 8'h48;
        start = log_pc.size();
        redirect_to(64'h40);
        run(20);
        check("t5_ntx", 80'(log_pc.size() - start), 80'(4));
        check("t5_stat", 80'(stat_o), 80'(3));
        check("t5_valid", 80'(inst_valid_o), 80'(0));
        err_en = 0;

        // invalid instruction, then recovery
        mem[8'h60] = 8'hC0;
        start = log_pc.size();
        redirect_to(64'h60);
        run(8);
        check("t6_ntx", 80'(log_pc.size() - start), 80'(1));
        if (log_pc.size() > start)
            check("t6_txpc", 80'(log_pc[start]), 80'(64'h60));
        check("t6_pc", 80'(pc_o), 80'(64'h61));
        check("t6_stat", 80'(stat_o), 80'(4));
        start = log_pc.size();
        redirect_to(64'h20);
        run(1);
        check("t6_stat_run", 80'(stat_o), 80'(1));
        run(6);
        check("t6_restart", 80'(log_pc.size() > start), 80'(1));

        // randomized program, stalls, redirects, latencies and errors
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            if (b[7:4] >= 4'hC && $urandom_range(0, 3) != 0)
                b[7:4] = 4'($urandom_range(1, 11));
            mem[i] = b;
        end
        for (int i = 0; i < 6000; i++) begin
            s_ready = ($urandom_range(0, 3) != 0);
            s_redir = ($urandom_range(0, 39) == 0)
                      || (m_stat != 1 && $urandom_range(0, 7) == 0);
            if (s_redir) begin
                s_rpc = {56'($urandom), 8'($urandom)};
                if ($urandom_range(0, 9) == 0) s_rpc[63:8] = '1;
                else if ($urandom_range(0, 1) == 0) s_rpc[63:8] = '0;
                lat = $urandom_range(1, 4);
                err_en = ($urandom_range(0, 3) == 0);
                err_lo = {5'($urandom), 3'b000};
            end
            cycle();
            s_redir = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
